// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key-cracker blocks: loader FSM states and widths.
package arc4_pkg;

    localparam int          KEY_W       = 24;
    localparam int          BYTE_W      = 8;
    localparam logic [7:0]  CT_LEN_ADDR = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEN       = 3'd1,
        ST_DATA      = 3'd2,
        ST_LAUNCH    = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5
    } ct_loader_state_t;

endpackage

// File: rtl/ct_loader.sv
// Streams a length-prefixed ciphertext into CT memory, launches the cracker,
// and latches the recovered key (or a timeout) for the top level.
module ct_loader
    import arc4_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                rdy,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic [7:0]          ct_addr,
    output logic [BYTE_W-1:0]   ct_wrdata,
    output logic                ct_wren,
    input  logic [7:0]          crack_ct_addr,
    output logic                crack_en,
    input  logic                crack_rdy,
    input  logic [KEY_W-1:0]    crack_key,
    input  logic                crack_key_valid,
    output logic [KEY_W-1:0]    key,
    output logic                key_valid,
    output logic                timed_out
);

    ct_loader_state_t   state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         wptr_q, wptr_d;
    logic [31:0]        timer_q, timer_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               kv_q, kv_d;
    logic               to_q, to_d;

    logic accept;
    logic crack_phase;
    logic timeout_hit;

    assign rdy         = (state_q == ST_IDLE);
    assign in_ready    = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign accept      = in_valid && in_ready;
    assign crack_phase = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (timer_q == TIMEOUT_CYCLES - 32'd1);

    // The cracker owns the read address for the whole crack phase.
    always_comb begin
        ct_addr = 8'd0;
        if (crack_phase)              ct_addr = crack_ct_addr;
        else if (state_q == ST_LEN)   ct_addr = CT_LEN_ADDR;
        else if (state_q == ST_DATA)  ct_addr = wptr_q;
    end

    assign ct_wren   = accept;
    assign ct_wrdata = accept ? in_data : '0;
    assign crack_en  = (state_q == ST_LAUNCH) && crack_rdy;

    assign key       = key_q;
    assign key_valid = kv_q;
    assign timed_out = to_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        timer_d = timer_q;
        key_d   = key_q;
        kv_d    = kv_q;
        to_d    = to_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LEN;
                    key_d   = '0;
                    kv_d    = 1'b0;
                    to_d    = 1'b0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_d   = in_data;
                    wptr_d  = 8'd1;
                    state_d = (in_data == 8'd0) ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                // Stop at wptr==L rather than incrementing, so L=255 never wraps.
                if (accept) begin
                    if (wptr_q == len_q) state_d = ST_LAUNCH;
                    else                 wptr_d  = wptr_q + 8'd1;
                end
            end
            ST_LAUNCH: begin
                if (crack_rdy) begin
                    timer_d = 32'd0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                timer_d = timer_q + 32'd1;
                if (timeout_hit) begin
                    to_d    = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (!crack_rdy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                timer_d = timer_q + 32'd1;
                // Completion takes priority over a coincident timeout.
                if (crack_rdy) begin
                    key_d   = crack_key;
                    kv_d    = crack_key_valid;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    to_d    = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= 8'd0;
            wptr_q  <= 8'd0;
            timer_q <= 32'd0;
            key_q   <= '0;
            kv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            timer_q <= timer_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
// Directed bench for ct_loader: stream loads, length-0 job, key return, timeout, mid-job reset.
module tb_ct_loader;
    import arc4_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               rdy;
    logic               in_valid;
    logic [BYTE_W-1:0]  in_data;
    logic               in_ready;
    logic [7:0]         ct_addr;
    logic [BYTE_W-1:0]  ct_wrdata;
    logic               ct_wren;
    logic [7:0]         crack_ct_addr;
    logic               crack_en;
    logic               crack_rdy;
    logic [KEY_W-1:0]   crack_key;
    logic               crack_key_valid;
    logic [KEY_W-1:0]   key;
    logic               key_valid;
    logic               timed_out;

    ct_loader #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
        .crack_ct_addr(crack_ct_addr), .crack_en(crack_en), .crack_rdy(crack_rdy),
        .crack_key(crack_key), .crack_key_valid(crack_key_valid),
        .key(key), .key_valid(key_valid), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int nwr  = 0;
    int ncen = 0;
    int n_chk = 0;
    int n_pass = 0;

    // Memory model: captures every write the loader commits on an edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (ct_wren) begin
                mem[ct_addr] = ct_wrdata;
                nwr++;
            end
            if (crack_en) ncen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after 'gap' idle cycles; in_valid is left high afterwards.
    task automatic send(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            if (i == 2) begin
                chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
                chk("gap_no_wren", {31'd0, ct_wren}, 32'd0);
            end
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    task automatic start_job();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    endtask

    int n0, c0, cnt;

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        crack_ct_addr = 8'h00; crack_rdy = 1'b1; crack_key = '0; crack_key_valid = 1'b0;
        clear_mem();
        #12;
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wren", {31'd0, ct_wren}, 32'd0);
        chk("rst_addr", {24'd0, ct_addr}, 32'd0);
        chk("rst_crack_en", {31'd0, crack_en}, 32'd0);
        chk("rst_key", {8'd0, key}, 32'd0);
        chk("rst_kv_to", {30'd0, key_valid, timed_out}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Job 1: back-to-back bytes, cracker initially busy
        crack_rdy = 1'b0;
        start_job();
        chk("j1_rdy_low", {31'd0, rdy}, 32'd0);
        chk("j1_in_ready", {31'd0, in_ready}, 32'd1);
        n0 = nwr;
        send(8'h03, 0); send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0);
        in_valid = 1'b0;
        chk("j1_nwr", nwr - n0, 32'd4);
        chk("j1_mem0", {24'd0, mem[0]}, 32'h03);
        chk("j1_mem1", {24'd0, mem[1]}, 32'hA1);
        chk("j1_mem2", {24'd0, mem[2]}, 32'hB2);
        chk("j1_mem3", {24'd0, mem[3]}, 32'hC3);
        chk("j1_launch_in_ready", {31'd0, in_ready}, 32'd0);
        tick(); tick();
        chk("j1_wait_crack_rdy", {31'd0, crack_en}, 32'd0);
        crack_rdy = 1'b1;
        #1;
        chk("j1_crack_en", {31'd0, crack_en}, 32'd1);
        tick();
        chk("j1_crack_en_once", {31'd0, crack_en}, 32'd0);
        crack_rdy = 1'b0;
        crack_ct_addr = 8'h37;
        #1;
        chk("j1_addr_busy", {24'd0, ct_addr}, 32'h37);
        tick(); tick(); tick();
        chk("j1_addr_done", {24'd0, ct_addr}, 32'h37);
        crack_key = 24'h1A2B3C; crack_key_valid = 1'b1; crack_rdy = 1'b1;
        tick();
        chk("j1_key", {8'd0, key}, 32'h1A2B3C);
        chk("j1_key_valid", {31'd0, key_valid}, 32'd1);
        chk("j1_rdy", {31'd0, rdy}, 32'd1);
        chk("j1_ncen", ncen, 32'd1);

        // Job 2: same bytes with 5-cycle gaps; result clears on accepted en
        clear_mem();
        start_job();
        chk("j2_key_clr", {7'd0, key_valid, key}, 32'd0);
        n0 = nwr;
        send(8'h03, 5); send(8'hA1, 5); send(8'hB2, 5); send(8'hC3, 5);
        in_valid = 1'b0;
        chk("j2_nwr", nwr - n0, 32'd4);
        chk("j2_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h03A1B2C3);
        c0 = ncen;
        tick();
        chk("j2_ncen", ncen - c0, 32'd1);
        crack_rdy = 1'b0; tick();
        crack_key = 24'h445566; crack_rdy = 1'b1; tick();
        chk("j2_key", {8'd0, key}, 32'h445566);

        // Job 3: zero length
        clear_mem();
        n0 = nwr; c0 = ncen;
        start_job();
        send(8'h00, 0);
        in_valid = 1'b0;
        chk("j3_rdy", {31'd0, rdy}, 32'd1);
        chk("j3_nwr", nwr - n0, 32'd1);
        chk("j3_mem0", {24'd0, mem[0]}, 32'h00);
        tick(); tick();
        chk("j3_ncen", ncen - c0, 32'd0);
        chk("j3_key_valid", {31'd0, key_valid}, 32'd0);

        // Job 4: cracker never finishes
        start_job();
        send(8'h01, 0); send(8'h55, 0);
        in_valid = 1'b0;
        tick();
        crack_rdy = 1'b0;
        cnt = 0;
        while (!rdy && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("j4_cycles", cnt, 32'd100);
        chk("j4_timed_out", {31'd0, timed_out}, 32'd1);
        chk("j4_key_valid", {31'd0, key_valid}, 32'd0);

        // Mid-DATA reset with in_valid held high
        start_job();
        send(8'h04, 0); send(8'h11, 0);
        in_data = 8'h22;
        rst_n = 1'b0;
        #2;
        chk("mr_rdy", {31'd0, rdy}, 32'd1);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_wren", {31'd0, ct_wren}, 32'd0);
        chk("mr_addr", {24'd0, ct_addr}, 32'd0);
        chk("mr_timed_out", {31'd0, timed_out}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh 2-byte job after reset; en during WAIT_DONE ignored
        start_job();
        send(8'h02, 0); send(8'h9A, 0); send(8'hBC, 0);
        in_valid = 1'b0;
        chk("j5_mem", {8'd0, mem[0], mem[1], mem[2]}, 32'h00029ABC);
        chk("j5_hold_launch", {31'd0, crack_en}, 32'd0);
        crack_rdy = 1'b1; tick();
        crack_rdy = 1'b0; tick();
        en = 1'b1; tick(); en = 1'b0;
        chk("j5_en_ignored", {31'd0, rdy}, 32'd0);
        crack_key = 24'h0ABCDE; crack_rdy = 1'b1; tick();
        chk("j5_key", {8'd0, key}, 32'h0ABCDE);
        chk("j5_done", {29'd0, rdy, key_valid, timed_out}, 32'b110);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
